// File: rtl/ifetch_pq_pkg.sv
// ifetch_pq_pkg: shared widths, opcodes, fill FSM states and immediate decoders for the fetch unit
package ifetch_pq_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  typedef enum logic {S_IDLE, S_WAIT_MEM} fill_state_e;
  function automatic logic [XLEN-1:0] imm_j(input logic [ILEN-1:0] i);
    return {{12{i[31]}}, i[19:12], i[20], i[30:21], 1'b0};
  endfunction
  function automatic logic [XLEN-1:0] imm_b(input logic [ILEN-1:0] i);
    return {{20{i[31]}}, i[7], i[30:25], i[11:8], 1'b0};
  endfunction
endpackage

// File: rtl/ifetch_pq_fetch_fifo.sv
// fetch_fifo: pointer-based fifo with flush; caller guarantees no push when full without a pop
module fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  always_comb begin
    empty_o = wr_q == rd_q;
    full_o = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    dout_o = mem_q[rd_q[AW-1:0]];
    wr_d = flush_i ? '0 : wr_q + {{AW{1'b0}}, push_i};
    rd_d = flush_i ? '0 : rd_q + {{AW{1'b0}}, pop_i};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/ifetch_pq.sv
// ifetch_pq: instruction fetch with direct-mapped icache, BHT/JAL prediction and a fetch queue
module ifetch_pq
  import ifetch_pq_pkg::*;
#(
  parameter int LINES       = 16,
  parameter int LINE_WORDS  = 16,
  parameter int BHT_ENTRIES = 256,
  parameter int FQ_DEPTH    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  output logic                       inst_valid,
  output logic [ILEN-1:0]            inst,
  output logic [XLEN-1:0]            inst_pc,
  output logic                       inst_pred_jump,
  input  logic                       inst_ready,
  output logic                       mc_en,
  output logic [XLEN-1:0]            mc_pc,
  input  logic                       mc_done,
  input  logic [LINE_WORDS*ILEN-1:0] mc_data,
  input  logic                       redirect_en,
  input  logic [XLEN-1:0]            redirect_pc,
  input  logic                       br_upd_en,
  input  logic                       br_upd_taken,
  input  logic [XLEN-1:0]            br_upd_pc
);
  localparam int OFF_W = $clog2(LINE_WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = XLEN - 2 - OFF_W - IDX_W;
  localparam int BHT_W = $clog2(BHT_ENTRIES);
  fill_state_e state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d, mc_pc_q, mc_pc_d, pred_pc;
  logic mc_en_q, mc_en_d;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q [LINES];
  logic [ILEN-1:0] data_q [LINES][LINE_WORDS];
  logic [1:0] bht_q [BHT_ENTRIES];
  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx, fidx;
  logic [TAG_W-1:0] tag;
  logic [BHT_W-1:0] bidx, uidx;
  logic [ILEN-1:0] cur_inst;
  logic hit, is_jal, pred_jump, push, pop, full, empty, fill, unused;
  assign off = pc_q[OFF_W+1:2];
  assign idx = pc_q[OFF_W+2 +: IDX_W];
  assign tag = pc_q[XLEN-1 -: TAG_W];
  assign fidx = mc_pc_q[OFF_W+2 +: IDX_W];
  assign bidx = pc_q[BHT_W+1:2];
  assign uidx = br_upd_pc[BHT_W+1:2];
  assign unused = ^{br_upd_pc[XLEN-1:BHT_W+2], br_upd_pc[1:0]};
  assign hit = valid_q[idx] && tag_q[idx] == tag;
  assign cur_inst = data_q[idx][off];
  assign is_jal = cur_inst[6:0] == OP_JAL;
  assign pred_jump = is_jal || (cur_inst[6:0] == OP_BRANCH && bht_q[bidx][1]);
  assign pred_pc = pc_q + (is_jal ? imm_j(cur_inst) : pred_jump ? imm_b(cur_inst) : 32'd4);
  assign pop = rdy && !empty && inst_ready;
  assign push = rdy && hit && !redirect_en && (!full || pop);
  assign fill = rdy && state_q == S_WAIT_MEM && mc_done;
  assign pc_d = !rdy ? pc_q : redirect_en ? redirect_pc : push ? pred_pc : pc_q;
  assign inst_valid = !empty;
  assign mc_en = mc_en_q;
  assign mc_pc = mc_pc_q;
  // a miss seen during a redirect is for a stale pc, so the request waits for the new one
  always_comb begin
    state_d = state_q;
    mc_en_d = mc_en_q;
    mc_pc_d = mc_pc_q;
    if (rdy && state_q == S_IDLE && !hit && !redirect_en) begin
      state_d = S_WAIT_MEM;
      mc_en_d = 1'b1;
      mc_pc_d = {pc_q[XLEN-1:OFF_W+2], {(OFF_W+2){1'b0}}};
    end else if (fill) begin
      state_d = S_IDLE;
      mc_en_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q <= '0;
      mc_en_q <= 1'b0;
      mc_pc_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'd0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      mc_en_q <= mc_en_d;
      mc_pc_q <= mc_pc_d;
      if (fill) valid_q[fidx] <= 1'b1;
      if (rdy && br_upd_en)
        bht_q[uidx] <= br_upd_taken ? (bht_q[uidx] == 2'd3 ? 2'd3 : bht_q[uidx] + 2'd1)
                                    : (bht_q[uidx] == 2'd0 ? 2'd0 : bht_q[uidx] - 2'd1);
    end
  end
  // the fill targets the requested line, which may differ from pc after a redirect
  always_ff @(posedge clk) begin
    if (fill) begin
      tag_q[fidx] <= mc_pc_q[XLEN-1 -: TAG_W];
      for (int w = 0; w < LINE_WORDS; w++) data_q[fidx][w] <= mc_data[w*ILEN +: ILEN];
    end
  end
  fetch_fifo #(.WIDTH(ILEN + XLEN + 1), .DEPTH(FQ_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (rdy && redirect_en),
    .din_i   ({cur_inst, pc_q, pred_jump}),
    .dout_o  ({inst, inst_pc, inst_pred_jump}),
    .full_o  (full),
    .empty_o (empty)
  );
endmodule

// File: tb/tb_ifetch_pq.sv
// tb_ifetch_pq: randomized scoreboard bench; expected stream walks a synthetic program image
module tb_ifetch_pq;
  localparam int LW = 16;
  localparam int BHT = 256;
  logic clk = 0, rst = 1, rdy = 1, inst_ready = 0, mc_done = 0;
  logic redirect_en = 0, br_upd_en = 0, br_upd_taken = 0, stray = 0;
  logic [31:0] redirect_pc = 0, br_upd_pc = 0;
  logic [LW*32-1:0] mc_data = '0;
  logic inst_valid, inst_pred_jump, mc_en;
  logic [31:0] inst, inst_pc, mc_pc;
  typedef struct packed {logic [31:0] inst; logic [31:0] pc; logic pj;} exp_t;
  exp_t exp_q[$];
  logic [31:0] fill_log[$];
  int bht_m[BHT];
  int errors = 0, checks = 0, mem_lat = 3;
  logic en_prev = 0;
  logic [31:0] pc_prev = 0;

  ifetch_pq dut (
    .clk(clk), .rst(rst), .rdy(rdy), .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_pred_jump(inst_pred_jump), .inst_ready(inst_ready), .mc_en(mc_en), .mc_pc(mc_pc),
    .mc_done(mc_done), .mc_data(mc_data), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .br_upd_en(br_upd_en), .br_upd_taken(br_upd_taken), .br_upd_pc(br_upd_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc_j(input int off);
    logic [31:0] i = off;
    return {i[20], i[10:1], i[11], i[19:12], 5'd0, 7'b1101111};
  endfunction
  function automatic logic [31:0] enc_b(input int off);
    logic [31:0] i = off;
    return {i[12], i[10:5], 5'd2, 5'd1, 3'b000, i[4:1], i[11], 7'b1100011};
  endfunction
  // program image: kind 0 = addi, 1 = jal, 2 = branch; off is the encoded byte offset
  function automatic void prog(input logic [31:0] a, output logic [31:0] w, output int kind, output int off);
    logic [31:0] h = a * 32'h9E3779B1;
    kind = 0;
    off = 0;
    if (a == 32'h10) begin kind = 1; off = 64; end
    else if (a == 32'h20) begin kind = 2; off = 8; end
    else if (a >= 32'h100) begin
      off = (int'(h[12:6]) - 16) * 4;
      kind = h[31:29] == 3'd0 ? 1 : h[31:29] <= 3'd2 ? 2 : 0;
    end
    w = kind == 1 ? enc_j(off) : kind == 2 ? enc_b(off) : {a[13:2], 5'd0, 3'b000, 5'd1, 7'b0010011};
  endfunction

  task automatic load_exp(input logic [31:0] start, input int k);
    logic [31:0] pc = start, w;
    int kind, off;
    logic tk;
    exp_q.delete();
    repeat (k) begin
      prog(pc, w, kind, off);
      tk = kind == 1 || (kind == 2 && bht_m[int'((pc >> 2) % BHT)] >= 2);
      exp_q.push_back('{inst: w, pc: pc, pj: tk});
      pc = tk ? pc + 32'(off) : pc + 32'd4;
    end
  endtask

  task automatic reset_model();
    foreach (bht_m[i]) bht_m[i] = 0;
    exp_q.delete();
    fill_log.delete();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic redirect(input logic [31:0] tgt, input int nupd, input logic [31:0] base, input int mode, input int k);
    int bi;
    for (int i = 0; i <= nupd; i++) begin
      tick();
      if (i == 0) exp_q.delete();
      rdy = 1;
      inst_ready = 0;
      redirect_en = 1;
      redirect_pc = tgt;
      br_upd_en = i < nupd;
      br_upd_pc = mode != 0 ? base : base + 32'($urandom_range(0, 31)) * 32'd4;
      br_upd_taken = mode == 1 ? 1'b1 : mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
      bi = int'((br_upd_pc >> 2) % BHT);
      if (br_upd_en && br_upd_taken && bht_m[bi] < 3) bht_m[bi]++;
      if (br_upd_en && !br_upd_taken && bht_m[bi] > 0) bht_m[bi]--;
    end
    tick();
    redirect_en = 0;
    br_upd_en = 0;
    load_exp(tgt, k);
  endtask

  task automatic run_stream(input int budget, input int rdy_off_pct);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      tick();
      rdy = $urandom_range(0, 99) >= rdy_off_pct;
      inst_ready = exp_q.size() > 0 && $urandom_range(0, 3) != 0;
      n++;
    end
    rdy = 1;
    inst_ready = 0;
    chk("stream_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // memory: answers after mem_lat cycles and holds mc_done until the request drops
  initial begin
    int lat = 0, kd, of;
    logic [31:0] w;
    forever begin
      @(posedge clk);
      #2;
      mc_done = 0;
      if (stray) begin
        mc_done = 1;
        mc_data = '1;
      end else if (!mc_en) lat = 0;
      else if (lat >= mem_lat) begin
        mc_done = 1;
        for (int i = 0; i < LW; i++) begin
          prog(mc_pc + 32'(i * 4), w, kd, of);
          mc_data[i*32 +: 32] = w;
        end
      end else lat++;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (mc_en && !en_prev) fill_log.push_back(mc_pc);
      if (mc_en && en_prev) begin
        checks++;
        if (mc_pc !== pc_prev) begin
          errors++;
          $display("FAIL mc_pc_stable: got %h expected %h", mc_pc, pc_prev);
        end
      end
      if (rdy && inst_valid && inst_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL sb_extra: got pc=%h with nothing expected", inst_pc);
        end else begin
          e = exp_q.pop_front();
          if ({inst, inst_pc, inst_pred_jump} !== e) begin
            errors++;
            $display("FAIL sb_pop: got pc=%h inst=%h pj=%b expected pc=%h inst=%h pj=%b",
                     inst_pc, inst, inst_pred_jump, e.pc, e.inst, e.pj);
          end
        end
      end
    end
    en_prev = mc_en;
    pc_prev = mc_pc;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: run did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [31:0] f0, f1;
    rst = 1;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_mc_en", mc_en, 0);
    chk("rst_mc_pc", mc_pc, 0);
    tick();
    rst = 0;
    stray = 1;
    reset_model();
    load_exp(32'h0, 24);
    tick();
    stray = 0;
    @(negedge clk);
    chk("cold_mc_en", mc_en, 1);
    chk("cold_mc_pc", mc_pc, 0);
    run_stream(400, 10);
    // consumer stalled: queue fills, pc parks inside the already-cached line
    redirect(32'h80, 0, 0, 0, 16);
    repeat (40) tick();
    @(negedge clk);
    chk("full_valid", inst_valid, 1);
    chk("full_head_pc", inst_pc, 32'h80);
    chk("full_no_fetch", mc_en, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      rdy = 0;
      inst_ready = 1;
      @(negedge clk);
      chk("frz_valid", inst_valid, 1);
      chk("frz_head_pc", inst_pc, 32'h80);
    end
    tick();
    rdy = 1;
    inst_ready = 0;
    run_stream(300, 10);
    redirect(32'h20, 2, 32'h20, 1, 4);
    run_stream(100, 0);
    redirect(32'h20, 2, 32'h20, 2, 4);
    run_stream(100, 0);
    for (int s = 0; s < 12; s++) begin
      logic [31:0] st = 32'($urandom_range(32'h40, 32'hFFF)) << 2;
      mem_lat = $urandom_range(1, 6);
      n = $urandom_range(0, 6);
      redirect(st, n, st, 0, $urandom_range(8, 30));
      run_stream(600, 20);
    end
    // reset while a fill is outstanding, with a stray mc_done right afterwards
    mem_lat = 12;
    redirect(32'h8000, 0, 0, 0, 0);
    n = 0;
    while (!(mc_en === 1'b1 && mc_pc === 32'h8000) && n < 20) begin
      tick();
      n++;
    end
    chk("abort_fill_seen", 32'(n < 20), 1);
    tick();
    rst = 1;
    tick();
    tick();
    rst = 0;
    stray = 1;
    reset_model();
    tick();
    stray = 0;
    @(negedge clk);
    chk("rerst_mc_en", mc_en, 1);
    chk("rerst_mc_pc", mc_pc, 0);
    redirect(32'h400, 2, 32'h400, 0, 12);
    run_stream(400, 10);
    f0 = fill_log.size() > 0 ? fill_log[0] : 32'hFFFF_FFFF;
    f1 = fill_log.size() > 1 ? fill_log[1] : 32'hFFFF_FFFF;
    chk("redir_fill0", f0, 32'h0);
    chk("redir_fill1", f1, 32'h400);
    mem_lat = 3;
    redirect(32'h0, 0, 0, 0, 10);
    run_stream(300, 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
